// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop walk the
// operands LSB first, then publish sum/cout/ovf with a one-cycle done pulse.
`timescale 1ns/1ps
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic [WIDTH-1:0]   opa, opb;
  logic [WIDTH-2:0]   part;
  logic               s_bit, c_bit, last_bit;
  logic [WIDTH-1:0]   part_nxt;

  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (x & ci) | (y & ci);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)    state_nxt = ST_RUN;
      ST_RUN:  if (last_bit) state_nxt = ST_DONE;
      ST_DONE:               state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // Full-adder cell; part keeps only the WIDTH-1 most recent bits because the
  // final bit goes straight into sum.
  always_comb begin
    s_bit    = fa_sum(opa[0], opb[0], carry);
    c_bit    = fa_carry(opa[0], opb[0], carry);
    part_nxt = {s_bit, part};
    last_bit = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      carry <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      part  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= c_bit;
          part  <= part_nxt[WIDTH-1:1];
          cnt   <= cnt + CNT_W'(1);
          // On the MSB step the incoming carry is the carry into the sign bit.
          if (last_bit) begin
            sum  <= part_nxt;
            cout <= c_bit;
            ovf  <= carry ^ c_bit;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
